rx_data_check: RTL

- Receive-side counterpart of the transmit PN data source.
- Consumes the demodulated, depacketized AXIS symbol stream and locks local PN5/PN4 predictors to it by self-synchronisation.
- Counts checked bits and bit errors, and reports per-packet length, modulation and error statistics.
- Sits after the depacketizer. Its outputs feed the status registers and the BER display.

---
 rtl/rx_data_check.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/rx_data_check.sv
// rx_data_check -- receive-side PN data checker.
//
// Locks a PN5 predictor (MSB of each beat) and a PN4 predictor (bit 0 of
// QPSK beats) to the incoming symbol stream by self-synchronisation, then
// counts checked bits and bit errors and reports per-packet statistics.
//
// Handshake: a beat transfers on any rising clk edge where data_tvalid and
// data_tready are both 1. data_tready is a registered constant 1 outside
// reset. No state moves on cycles without a transfer.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   clear             zero bit_cnt, err_cnt, pkt_cnt, proto_err (sync kept)
//   data_t*           AXIS symbol input; tuser = 1 marks a BPSK beat
//   sync_5, sync_4    PN5 / PN4 checker is in CHECK
//   bit_cnt, err_cnt  total checked / mismatched bits, saturating
//   pkt_cnt           completed packets, wrapping
//   pkt_done          one-cycle pulse after a tlast beat
//   pkt_is_bpsk, pkt_len, pkt_err  statistics of the last completed packet
//   proto_err         sticky: tuser changed inside a packet

// Self-synchronising checker for one PN sequence of order N
// (b[k] = b[k-3] ^ b[k-N]). The shift register holds the hunted bits in
// HUNT and the local LFSR in CHECK; bit 0 is the most recent bit.
module rx_pn_checker #(
    parameter int N           = 5,
    parameter int LOSS_THRESH = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,       // a bit for this checker arrives this cycle
    input  logic bit_in,
    output logic sync,     // checker state: 1 = CHECK
    output logic chk,      // bit_in is counted this cycle
    output logic err       // bit_in mismatches the prediction
);
    typedef enum logic {HUNT = 1'b0, CHECK = 1'b1} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   sr_q, sr_d;
    logic [2:0]     fill_q, fill_d;
    logic [3:0]     miss_q, miss_d;
    logic           pred;

    assign pred = sr_q[2] ^ sr_q[N-1];
    assign sync = (state_q == CHECK);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= HUNT;
            sr_q    <= '0;
            fill_q  <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            fill_q  <= fill_d;
            miss_q  <= miss_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        fill_d  = fill_q;
        miss_d  = miss_q;
        chk     = 1'b0;
        err     = 1'b0;
        if (en) begin
            case (state_q)
                HUNT: begin
                    sr_d   = {sr_q[N-2:0], bit_in};
                    fill_d = fill_q + 3'd1;
                    if (fill_q + 3'd1 == 3'(N)) begin
                        // Register now holds N received bits: it becomes the LFSR.
                        state_d = CHECK;
                        fill_d  = '0;
                        miss_d  = '0;
                    end
                end
                CHECK: begin
                    chk  = 1'b1;
                    // Shift in the prediction so a bit error does not propagate.
                    sr_d = {sr_q[N-2:0], pred};
                    if (bit_in != pred) begin
                        err    = 1'b1;
                        miss_d = miss_q + 4'd1;
                        if (miss_q + 4'd1 >= 4'(LOSS_THRESH)) begin
                            state_d = HUNT;
                            sr_d    = '0;
                            fill_d  = '0;
                            miss_d  = '0;
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end
endmodule

module rx_data_check #(
    parameter int BYTES       = 1,
    parameter int LOSS_THRESH = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic [BYTES*8-1:0]   data_tdata,
    input  logic                 data_tvalid,
    output logic                 data_tready,
    input  logic                 data_tlast,
    input  logic                 data_tuser,
    output logic                 sync_5,
    output logic                 sync_4,
    output logic [31:0]          bit_cnt,
    output logic [31:0]          err_cnt,
    output logic [15:0]          pkt_cnt,
    output logic                 pkt_done,
    output logic                 pkt_is_bpsk,
    output logic [15:0]          pkt_len,
    output logic [15:0]          pkt_err,
    output logic                 proto_err
);
    localparam int BITS = BYTES * 8;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [1:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {31'd0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {15'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    logic        accept;
    logic        chk5, err5, chk4, err4;
    logic [1:0]  chk_n, err_n;
    logic        first_q;     // next accepted beat starts a packet
    logic        cur_bpsk_q;  // modulation latched on the packet's first beat
    logic [15:0] run_len_q, run_err_q;
    logic [31:0] bit_base, err_base, bit_nxt, err_nxt;
    logic [15:0] pkt_cnt_base, pkt_cnt_nxt, run_len_inc, run_err_inc;
    logic        proto_nxt, pkt_bpsk_eff;
    logic        unused_mid_bits;

    assign accept          = data_tvalid & data_tready;
    assign unused_mid_bits = ^data_tdata[BITS-2:1];

    rx_pn_checker #(.N(5), .LOSS_THRESH(LOSS_THRESH)) u_pn5 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (accept),
        .bit_in (data_tdata[BITS-1]),
        .sync   (sync_5),
        .chk    (chk5),
        .err    (err5)
    );

    // BPSK beats carry no PN4 bit, so the PN4 checker holds still on them.
    rx_pn_checker #(.N(4), .LOSS_THRESH(LOSS_THRESH)) u_pn4 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (accept & ~data_tuser),
        .bit_in (data_tdata[0]),
        .sync   (sync_4),
        .chk    (chk4),
        .err    (err4)
    );

    assign chk_n = {1'b0, chk5} + {1'b0, chk4};
    assign err_n = {1'b0, err5} + {1'b0, err4};

    // clear zeroes the totals first; the current beat then adds on top.
    always_comb begin
        bit_base     = clear ? '0 : bit_cnt;
        err_base     = clear ? '0 : err_cnt;
        pkt_cnt_base = clear ? '0 : pkt_cnt;
        bit_nxt      = sat_add32(bit_base, chk_n);
        err_nxt      = sat_add32(err_base, err_n);
        pkt_cnt_nxt  = pkt_cnt_base + {15'd0, accept & data_tlast};
        proto_nxt    = (proto_err & ~clear) |
                       (accept & ~first_q & (data_tuser != cur_bpsk_q));
        pkt_bpsk_eff = first_q ? data_tuser : cur_bpsk_q;
        run_len_inc  = sat_add16(run_len_q, 2'd1);
        run_err_inc  = sat_add16(run_err_q, err_n);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_tready <= 1'b0;
            bit_cnt     <= '0;
            err_cnt     <= '0;
            pkt_cnt     <= '0;
            pkt_done    <= 1'b0;
            pkt_is_bpsk <= 1'b0;
            pkt_len     <= '0;
            pkt_err     <= '0;
            proto_err   <= 1'b0;
            first_q     <= 1'b1;
            cur_bpsk_q  <= 1'b0;
            run_len_q   <= '0;
            run_err_q   <= '0;
        end else begin
            data_tready <= 1'b1;
            pkt_done    <= 1'b0;
            bit_cnt     <= bit_nxt;
            err_cnt     <= err_nxt;
            pkt_cnt     <= pkt_cnt_nxt;
            proto_err   <= proto_nxt;
            if (accept) begin
                if (first_q) cur_bpsk_q <= data_tuser;
                if (data_tlast) begin
                    pkt_done    <= 1'b1;
                    pkt_len     <= run_len_inc;
                    pkt_err     <= run_err_inc;
                    pkt_is_bpsk <= pkt_bpsk_eff;
                    run_len_q   <= '0;
                    run_err_q   <= '0;
                    first_q     <= 1'b1;
                end else begin
                    run_len_q   <= run_len_inc;
                    run_err_q   <= run_err_inc;
                    first_q     <= 1'b0;
                end
            end
        end
    end
endmodule
